// File: rtl/dadd_accum_pkg.sv
// dadd_accum_pkg: constants shared by the blitter data-path accumulator stage.
//   - lane packing (LANES lanes of LW bits in one PW-bit phrase)
//   - sequencer state encodings
//   - daddmode encodings driven to the saturating adder array
package dadd_accum_pkg;

  localparam int LANES = 4;            // fixed to match the adder array
  localparam int LW    = 16;           // lane width
  localparam int PW    = LANES * LW;   // phrase width
  localparam int CNTW  = 16;           // step counter width

  // Sequencer states (legacy two-bit encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Adder modes used by the blitter control
  localparam logic [2:0] DMODE_ADD_WRAP  = 3'b000;  // plain modulo add
  localparam logic [2:0] DMODE_INT_SAT   = 3'b001;  // 8-bit intensity saturate
  localparam logic [2:0] DMODE_Z_SAT     = 3'b010;  // 16-bit Z saturate
  localparam logic [2:0] DMODE_ADD_CARRY = 3'b100;  // add with latched carry

  // Bit offset of lane n inside a phrase
  function automatic int lane_ofs(input int n);
    return n * LW;
  endfunction

endpackage

// File: rtl/dadd_accum_if.sv
// dadd_accum_if: downstream phrase stream.
//   out_valid : producer has a phrase on out_data
//   out_ready : consumer accepts the phrase
//   out_data  : current phrase (LANES x LW bits)
// Handshake: a phrase is transferred on a rising clock edge where
// out_valid and out_ready are both high (the producer may additionally
// qualify the transfer with its own enable). While out_valid is high and
// no transfer occurs, out_data is held stable; out_valid never drops
// without a transfer except on reset.
interface dadd_accum_if;
  logic                         out_valid;
  logic                         out_ready;
  logic [dadd_accum_pkg::PW-1:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/dadd_accum.sv
// dadd_accum: accumulator/sequencer around the four-lane saturating adder.
// Holds the current phrase (value) and per-lane increments, feeds them to
// the adder as A/B operands, and captures the adder result as the next
// phrase on every accepted step. Emits step_cnt phrases, then pulses done.
//
// Ports:
//   sys_clk, reset_n : clock, synchronous active-low reset
//   tick             : clk_0 rising-edge strobe; steps only happen with it
//   start            : begin a run (sampled in IDLE only)
//   mode             : adder mode, latched at start
//   init_val/init_inc: initial phrase and per-lane increments
//   step_cnt         : number of phrases to emit
//   out_if           : phrase stream (master)
//   busy, done       : run in progress / one-cycle completion pulse
//   adda, addb       : adder A/B operands (value / increment registers)
//   daddmode         : adder mode (latched)
//   addq             : adder result, combinational from adda/addb
//   dbg_state        : current sequencer state
module dadd_accum
  import dadd_accum_pkg::*;
(
  input  logic            sys_clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [PW-1:0]   init_val,
  input  logic [PW-1:0]   init_inc,
  input  logic [CNTW-1:0] step_cnt,
  dadd_accum_if.master    out_if,
  output logic            busy,
  output logic            done,
  output logic [PW-1:0]   adda,
  output logic [PW-1:0]   addb,
  output logic [2:0]      daddmode,
  input  logic [PW-1:0]   addq,
  output logic [1:0]      dbg_state
);

  logic [1:0]      r_state;
  logic [PW-1:0]   r_value;
  logic [PW-1:0]   r_inc;
  logic [2:0]      r_mode;
  logic [CNTW-1:0] r_cnt;
  logic            w_step;

  // A step is a downstream transfer on a clk_0 edge. Advancing only on tick
  // keeps value in lock-step with the adder's carry latch, which also
  // updates on clk_0.
  assign w_step = (r_state == ST_RUN) && out_if.out_ready && tick;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_value <= '0;
      r_inc   <= '0;
      r_mode  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_value <= init_val;
            r_inc   <= init_inc;
            r_mode  <= mode;
            r_cnt   <= step_cnt;
            r_state <= (step_cnt == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // r_cnt is at least 1 in RUN, so the decrement cannot underflow
          if (w_step) begin
            r_value <= addq;
            r_cnt   <= r_cnt - 1'b1;
            if (r_cnt == CNTW'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_if.out_valid = (r_state == ST_RUN);
  assign out_if.out_data  = r_value;
  assign busy             = (r_state == ST_RUN);
  assign done             = (r_state == ST_DONE);
  // Operands stay driven after the run so the adder inputs are unchanged
  // until the next start.
  assign adda             = r_value;
  assign addb             = r_inc;
  assign daddmode         = r_mode;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_dadd_accum.sv
// Directed bench for dadd_accum with a behavioural mode-000 adder array
// (lane-wise modulo 2^16 add) connected to adda/addb/addq.
module tb_dadd_accum;
  import dadd_accum_pkg::*;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic            reset_n;
  logic            tick;
  logic            start;
  logic [2:0]      mode;
  logic [PW-1:0]   init_val;
  logic [PW-1:0]   init_inc;
  logic [CNTW-1:0] step_cnt;
  logic            busy;
  logic            done;
  logic [PW-1:0]   adda;
  logic [PW-1:0]   addb;
  logic [2:0]      daddmode;
  logic [PW-1:0]   addq;
  logic [1:0]      dbg_state;

  dadd_accum_if out_if();

  dadd_accum dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .start    (start),
    .mode     (mode),
    .init_val (init_val),
    .init_inc (init_inc),
    .step_cnt (step_cnt),
    .out_if   (out_if),
    .busy     (busy),
    .done     (done),
    .adda     (adda),
    .addb     (addb),
    .daddmode (daddmode),
    .addq     (addq),
    .dbg_state(dbg_state)
  );

  // Adder array model, mode 000: independent wrapping lanes
  always_comb begin
    addq = '0;
    for (int i = 0; i < LANES; i++)
      addq[i*LW +: LW] = adda[i*LW +: LW] + addb[i*LW +: LW];
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs,
                     input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after an edge; outputs are sampled 1 time unit
  // after the next edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rep(input logic [LW-1:0] v);
    return {LANES{v}};
  endfunction

  initial begin
    reset_n  = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    mode     = DMODE_ADD_WRAP;
    init_val = '0;
    init_inc = '0;
    step_cnt = '0;
    out_if.out_ready = 1'b1;

    // ---- reset state ----
    cyc(0); cyc(0);
    chk("rst_state", PW'(dbg_state), PW'(ST_IDLE));
    chk("rst_valid", PW'(out_if.out_valid), '0);
    chk("rst_busy",  PW'(busy), '0);
    chk("rst_done",  PW'(done), '0);
    chk("rst_adda",  adda, '0);
    chk("rst_addb",  addb, '0);
    chk("rst_mode",  PW'(daddmode), '0);
    reset_n = 1'b1;
    cyc(0);

    // ---- basic run: 3 phrases, tick every 2nd cycle ----
    init_val = rep(16'h0010);
    init_inc = rep(16'h0001);
    step_cnt = 16'd3;
    start    = 1'b1;
    cyc(0);
    start = 1'b0;
    chk("t1_valid0", PW'(out_if.out_valid), PW'(1));
    chk("t1_busy0",  PW'(busy), PW'(1));
    chk("t1_ph0",    out_if.out_data, rep(16'h0010));
    chk("t1_addb",   addb, rep(16'h0001));
    cyc(0);
    chk("t1_notick", out_if.out_data, rep(16'h0010));
    cyc(1);
    chk("t1_ph1",    out_if.out_data, rep(16'h0011));
    cyc(0);
    cyc(1);
    chk("t1_ph2",    out_if.out_data, rep(16'h0012));
    chk("t1_nodone", PW'(done), '0);
    cyc(0);
    cyc(1);
    chk("t1_done",   PW'(done), PW'(1));
    chk("t1_dvalid", PW'(out_if.out_valid), '0);
    chk("t1_dbusy",  PW'(busy), '0);
    cyc(0);
    chk("t1_done1",  PW'(done), '0);
    chk("t1_idle",   PW'(dbg_state), PW'(ST_IDLE));
    chk("t1_keepa",  adda, rep(16'h0013));
    chk("t1_keepb",  addb, rep(16'h0001));

    // ---- back-pressure for 5 tick periods after first phrase ----
    start = 1'b1;
    cyc(0);
    start = 1'b0;
    chk("t2_ph0", out_if.out_data, rep(16'h0010));
    out_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0);
      cyc(1);
      chk("t2_hold", out_if.out_data, rep(16'h0010));
      chk("t2_hvld", PW'(out_if.out_valid), PW'(1));
    end
    out_if.out_ready = 1'b1;
    cyc(0); cyc(1);
    chk("t2_ph1", out_if.out_data, rep(16'h0011));
    cyc(0); cyc(1);
    chk("t2_ph2", out_if.out_data, rep(16'h0012));
    chk("t2_run", PW'(dbg_state), PW'(ST_RUN));
    cyc(0); cyc(1);
    chk("t2_done", PW'(done), PW'(1));
    cyc(0);

    // ---- step_cnt = 0: straight to DONE ----
    step_cnt = 16'd0;
    start    = 1'b1;
    cyc(0);
    start = 1'b0;
    chk("t3_done",  PW'(done), PW'(1));
    chk("t3_valid", PW'(out_if.out_valid), '0);
    cyc(0);
    chk("t3_done1", PW'(done), '0);
    chk("t3_vld1",  PW'(out_if.out_valid), '0);

    // ---- lane-0 wrap, other lanes independent ----
    init_val = {16'h3000, 16'h2000, 16'h1000, 16'hFFFF};
    init_inc = rep(16'h0001);
    step_cnt = 16'd2;
    start    = 1'b1;
    cyc(0);
    start = 1'b0;
    chk("t4_ph0", out_if.out_data, {16'h3000, 16'h2000, 16'h1000, 16'hFFFF});
    cyc(1);
    chk("t4_ph1", out_if.out_data, {16'h3001, 16'h2001, 16'h1001, 16'h0000});
    cyc(1);
    chk("t4_done", PW'(done), PW'(1));
    cyc(0);

    // ---- reset in the middle of a run ----
    init_val = rep(16'h0010);
    step_cnt = 16'd5;
    start    = 1'b1;
    cyc(0);
    start = 1'b0;
    chk("t5_run", PW'(dbg_state), PW'(ST_RUN));
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    chk("t5_state", PW'(dbg_state), PW'(ST_IDLE));
    chk("t5_valid", PW'(out_if.out_valid), '0);
    chk("t5_data",  out_if.out_data, '0);
    chk("t5_addb",  addb, '0);
    chk("t5_busy",  PW'(busy), '0);
    chk("t5_done",  PW'(done), '0);
    cyc(0);
    chk("t5_nodone", PW'(done), '0);

    // ---- start during RUN is ignored ----
    init_val = rep(16'h0010);
    step_cnt = 16'd2;
    start    = 1'b1;
    cyc(0);
    init_val = rep(16'h5555);
    chk("t6_ph0", out_if.out_data, rep(16'h0010));
    cyc(1);
    chk("t6_ph1", out_if.out_data, rep(16'h0011));
    cyc(1);
    chk("t6_done", PW'(done), PW'(1));
    start = 1'b0;
    cyc(0);
    chk("t6_keepa", adda, rep(16'h0012));
    chk("t6_idle",  PW'(dbg_state), PW'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
